// File: rtl/csr_regfile_pkg.sv
// -----------------------------------------------------------------------------
// csr_regfile_pkg
//
// Shared definitions for the machine-mode CSR block. The address constants are
// shared with the interrupt controller and the decoder. The package holds:
//   - CSR address constants
//   - mstatus bit positions
//   - write-mask constants
//   - helpers: writability test, read-alias canonicalisation, write masking,
//     and the per-address write resolver (clint over EX)
// -----------------------------------------------------------------------------
package csr_regfile_pkg;

    // Machine-mode read/write CSRs
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Read-only CSRs
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Write masks
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MIE, MPIE
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP hard-wired to 11
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;  // MSIE, MTIE, MEIE
    localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;  // mtvec / mepc

    // True for every address that accepts a write.
    function automatic logic csr_is_writable(input logic [11:0] addr);
        logic w;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // The user-level counter addresses are read aliases of the m-counters.
    // Folding them onto one address lets the read bypass treat them as the
    // same storage.
    function automatic logic [11:0] csr_canon(input logic [11:0] addr);
        logic [11:0] c;
        case (addr)
            CSR_CYCLE:    c = CSR_MCYCLE;
            CSR_CYCLEH:   c = CSR_MCYCLEH;
            CSR_INSTRET:  c = CSR_MINSTRET;
            CSR_INSTRETH: c = CSR_MINSTRETH;
            default:      c = addr;
        endcase
        return c;
    endfunction

    // Value actually stored when wd is written to addr.
    function automatic logic [31:0] csr_wmask(input logic [11:0] addr,
                                              input logic [31:0] wd);
        logic [31:0] v;
        case (addr)
            CSR_MSTATUS:         v = (wd & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MIE:             v = wd & MIE_WMASK;
            CSR_MTVEC, CSR_MEPC: v = wd & ALIGN4_MASK;
            default:             v = wd;
        endcase
        return v;
    endfunction

    // Resolves the two write ports for one target address. Returns
    // {write, masked data}. c_ok / e_ok must already be qualified (enable,
    // writable address, EX dropped on an address collision), so a clint hit
    // simply takes precedence.
    function automatic logic [32:0] csr_resolve(input logic [11:0] a,
                                                input logic        c_ok,
                                                input logic [11:0] c_wa,
                                                input logic [31:0] c_m,
                                                input logic        e_ok,
                                                input logic [11:0] e_wa,
                                                input logic [31:0] e_m);
        logic [32:0] r;
        if (c_ok && (c_wa == a)) begin
            r = {1'b1, c_m};
        end else if (e_ok && (e_wa == a)) begin
            r = {1'b1, e_m};
        end else begin
            r = 33'h0;
        end
        return r;
    endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// -----------------------------------------------------------------------------
// csr_counter64
//
// 64-bit free-running counter with separately writable halves.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   inc      : add one this cycle
//   we_lo    : load low half from wd_lo; high half holds, no increment
//   we_hi    : load high half from wd_hi; low half still increments, but the
//              carry out of it is lost
//   count    : current 64-bit value
// Both halves may be written in the same cycle. Wraps silently at 2^64.
// -----------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wd_lo,
    input  logic [31:0] wd_hi,
    output logic [63:0] count
);

    logic [63:0] sum;
    logic [31:0] lo_next;
    logic [31:0] hi_next;

    always_comb begin
        sum     = count + {63'h0, inc};
        lo_next = we_lo ? wd_lo : sum[31:0];
        // A low-half write suppresses the increment, so the carry into the
        // high half must not appear either.
        if (we_hi) begin
            hi_next = wd_hi;
        end else if (we_lo) begin
            hi_next = count[63:32];
        end else begin
            hi_next = sum[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 64'h0;
        end else begin
            count <= {hi_next, lo_next};
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// -----------------------------------------------------------------------------
// csr_regfile
//
// Machine-mode CSR register file for the RV32 pipeline.
//   clk, rst                  : clock, asynchronous active-high reset
//   id_csr_ra / id_csr_rd     : ID-stage combinational read, with same-cycle
//                               write bypass
//   id_csr_illegal            : id_csr_ra is not an implemented CSR
//   ex_csr_we/wa/wd           : EX-stage write port (final value)
//   clint_csr_we/wa/wd        : interrupt controller write port, wins over EX
//                               on the same address
//   inst_retire               : minstret increment
//   csr_mtvec, csr_mepc,
//   csr_mstatus               : registered CSR values for the interrupt ctrl
//   interrupt_enable          : mstatus.MIE
// -----------------------------------------------------------------------------
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] id_csr_ra,
    output logic [31:0] id_csr_rd,
    output logic        id_csr_illegal,
    input  logic        ex_csr_we,
    input  logic [11:0] ex_csr_wa,
    input  logic [31:0] ex_csr_wd,
    input  logic        clint_csr_we,
    input  logic [11:0] clint_csr_wa,
    input  logic [31:0] clint_csr_wd,
    input  logic        inst_retire,
    output logic [31:0] csr_mtvec,
    output logic [31:0] csr_mepc,
    output logic [31:0] csr_mstatus,
    output logic        interrupt_enable
);

    // ---------------------------------------------------------------------
    // Write port qualification
    // ---------------------------------------------------------------------
    logic        clint_ok;
    logic        ex_ok;
    logic [31:0] clint_m;
    logic [31:0] ex_m;

    assign clint_ok = clint_csr_we && csr_is_writable(clint_csr_wa);
    // EX loses a same-address collision with the interrupt controller.
    assign ex_ok    = ex_csr_we && csr_is_writable(ex_csr_wa)
                      && !(clint_ok && (clint_csr_wa == ex_csr_wa));
    assign clint_m  = csr_wmask(clint_csr_wa, clint_csr_wd);
    assign ex_m     = csr_wmask(ex_csr_wa, ex_csr_wd);

    // Per-CSR resolved writes: bit 32 = write, 31:0 = masked data
    logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
    logic [32:0] w_mcycle, w_mcycleh, w_minstret, w_minstreth;

    assign w_mstatus   = csr_resolve(CSR_MSTATUS,   clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mie       = csr_resolve(CSR_MIE,       clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mtvec     = csr_resolve(CSR_MTVEC,     clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mscratch  = csr_resolve(CSR_MSCRATCH,  clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mepc      = csr_resolve(CSR_MEPC,      clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mcause    = csr_resolve(CSR_MCAUSE,    clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mcycle    = csr_resolve(CSR_MCYCLE,    clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_mcycleh   = csr_resolve(CSR_MCYCLEH,   clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_minstret  = csr_resolve(CSR_MINSTRET,  clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);
    assign w_minstreth = csr_resolve(CSR_MINSTRETH, clint_ok, clint_csr_wa, clint_m, ex_ok, ex_csr_wa, ex_m);

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET & ALIGN4_MASK;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
        end else begin
            if (w_mstatus[32])  mstatus_q  <= w_mstatus[31:0];
            if (w_mie[32])      mie_q      <= w_mie[31:0];
            if (w_mtvec[32])    mtvec_q    <= w_mtvec[31:0];
            if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
            if (w_mepc[32])     mepc_q     <= w_mepc[31:0];
            if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
        end
    end

    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (w_mcycle[32]),
        .we_hi (w_mcycleh[32]),
        .wd_lo (w_mcycle[31:0]),
        .wd_hi (w_mcycleh[31:0]),
        .count (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (inst_retire),
        .we_lo (w_minstret[32]),
        .we_hi (w_minstreth[32]),
        .wd_lo (w_minstret[31:0]),
        .wd_hi (w_minstreth[31:0]),
        .count (minstret_q)
    );

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    assign csr_mtvec        = mtvec_q;
    assign csr_mepc         = mepc_q;
    assign csr_mstatus      = mstatus_q;
    assign interrupt_enable = mstatus_q[MSTATUS_MIE];

    // ---------------------------------------------------------------------
    // ID read port
    // ---------------------------------------------------------------------
    logic [11:0] ra_c;
    logic [31:0] rd_stored;
    logic [32:0] rd_bypass;

    always_comb begin
        ra_c           = csr_canon(id_csr_ra);
        rd_stored      = 32'h0;
        id_csr_illegal = 1'b0;
        case (ra_c)
            CSR_MSTATUS:   rd_stored = mstatus_q;
            CSR_MIE:       rd_stored = mie_q;
            CSR_MTVEC:     rd_stored = mtvec_q;
            CSR_MSCRATCH:  rd_stored = mscratch_q;
            CSR_MEPC:      rd_stored = mepc_q;
            CSR_MCAUSE:    rd_stored = mcause_q;
            CSR_MCYCLE:    rd_stored = mcycle_q[31:0];
            CSR_MCYCLEH:   rd_stored = mcycle_q[63:32];
            CSR_MINSTRET:  rd_stored = minstret_q[31:0];
            CSR_MINSTRETH: rd_stored = minstret_q[63:32];
            CSR_MHARTID:   rd_stored = MHARTID;
            default:       id_csr_illegal = 1'b1;
        endcase
        // A write landing this cycle is forwarded. Read-only and unknown
        // addresses never qualify, so the bypass cannot mask an illegal read.
        rd_bypass = csr_resolve(ra_c, clint_ok, clint_csr_wa, clint_m,
                                ex_ok, ex_csr_wa, ex_m);
        id_csr_rd = rd_bypass[32] ? rd_bypass[31:0] : rd_stored;
    end

endmodule
